lsb_queue: RTL
==============

// Module: lsb_queue
// PURPOSE
//  Parametrised in-order load/store queue between dispatch, ROB, CDB and memctrl.
//  - Holds up to DEPTH memory ops in a circular buffer.
//  - Snoops the ALU broadcast and its own load broadcast to resolve operand tags.
//  - Issues the head entry to memctrl with a valid/ready request and a response strobe.
//  - Reports load results and store completion to the ROB and RS.
// PARAMETERS
//  DEPTH      16          entries; power of two, >=2
//  ROB_TAG_W  4           ROB tag width
//  XLEN       32          data/address width
//  IO_BASE    32'h30000   addresses >= IO_BASE are I/O (non-speculative)
// PORTS
//  clk            in   1          clock
//  rst            in   1          async active-high reset
//  rdy            in   1          global stall: low freezes all state, outputs hold
//  flush          in   1          mispredict clear
//  disp_valid     in   1          enqueue one op (ignored when full)
//  disp_op        in   OP_W       lsb_pkg op code (LB/LH/LW/LBU/LHU/SB/SH/SW)
//  disp_qj_v/disp_qj/disp_vj  in  1/ROB_TAG_W/XLEN  base: tag pending, tag, value
//  disp_qk_v/disp_qk/disp_vk  in  1/ROB_TAG_W/XLEN  store data: tag pending, tag, value
//  disp_imm       in   XLEN       sign-extended offset
//  disp_rob       in   ROB_TAG_W  ROB tag of this op
//  full           out  1          count==DEPTH
//  count          out  $clog2(DEPTH)+1  occupancy
//  cdb_valid/cdb_tag/cdb_data  in  1/ROB_TAG_W/XLEN  ALU result broadcast
//  rob_commit_valid/rob_commit_tag  in  1/ROB_TAG_W   ROB head reached this op
//  mem_req_valid  out  1          request valid, held until mem_req_ready
//  mem_req_ready  in   1          memctrl accepts
//  mem_req_we/mem_req_size/mem_req_addr/mem_req_wdata  out  1/2/XLEN/XLEN
//  mem_resp_valid/mem_resp_data  in  1/XLEN  one-cycle response strobe; stores also respond
//  ld_valid/ld_tag/ld_data  out  1/ROB_TAG_W/XLEN  extended load result, 1-cycle pulse
//  st_done_valid/st_done_tag  out  1/ROB_TAG_W  store written, 1-cycle pulse
// BEHAVIOUR
//  - Reset: all outputs 0, head=tail=0, count=0, state IDLE, every entry invalid.
//  - Enqueue:
//    - Write at tail; the entry is usable the next cycle.
//    - A same-cycle CDB/ld broadcast matching a dispatch tag is captured (bypass).
//  - Snoop: every cycle, each valid entry whose qj/qk matches cdb_tag or ld_tag clears
//    its pending bit and takes the data. The two buses never carry the same tag.
//  - Commit: an entry with rob == rob_commit_tag sets committed=1. A commit in the
//    dispatch cycle of that tag is captured.
//  - Addr = vj + imm, mod 2^XLEN.
//  - FSM, head entry only:
//    - IDLE -> REQ when head is valid, base ready, and issue rule holds.
//      Stores also need data ready.
//    - REQ: mem_req_valid=1, fields stable. On mem_req_ready -> WAIT.
//    - WAIT -> IDLE on mem_resp_valid, which pops the head (count-1, head wraps mod DEPTH).
//      - Load: ld_valid=1 next cycle with ld_data sign/zero-extended per op.
//      - Store: st_done_valid=1 next cycle.
//  - Issue rule: stores always require committed=1.
//  - Simultaneous enqueue and pop: count unchanged. Enqueue when full is dropped; full stays 1.
//  - Flush:
//    - All entries invalid, head=tail=0, count=0. The flush cycle's dispatch is ignored.
//    - From REQ, go to IDLE.
//    - From WAIT, go to DRAIN: swallow the pending response with no ld/st pulse,
//      then IDLE. No issue while in DRAIN.
//  - rdy low overrides everything except rst. Flush takes precedence over all non-reset events.
// CONFIGURATION
//  LSB_LOAD_SPEC_EN defined:
//    - Loads with addr < IO_BASE issue without commit.
//    - Loads with addr >= IO_BASE wait for commit.
//  LSB_LOAD_SPEC_EN undefined:
//    - Every load waits for committed=1, i.e. fully in-order.
// STRUCTURE
//  lsb_pkg:
//    - op codes, OP_W, size encoding, entry struct (op, qj_v, qj, vj, qk_v, qk, vk, imm,
//      rob, committed, valid).
//    - FSM state enum {IDLE, REQ, WAIT, DRAIN}.
//  Sub-module lsb_load_ext: combinational byte/half/word sign/zero extension.
//  Queue storage, snoop and FSM stay in lsb_queue.
// TESTING
//  1 LW qj pending tag 3. cdb tag3 data 0x100, imm 4, commit tag 3
//    -> mem_req addr 0x104, we=0. resp 0xFFFF_FF80 -> ld_data 0xFFFF_FF80.
//  2 LB: resp 0x0000_0080 -> ld_data 0xFFFF_FF80. LBU -> 0x0000_0080.
//  3 SW vj=0x200, vk=0xDEAD_BEEF
//    -> no mem_req before rob_commit_tag.
//    -> then addr 0x200, wdata 0xDEAD_BEEF, st_done pulse.
//  4 Fill DEPTH entries
//    -> full=1, next dispatch dropped.
//    -> pop and enqueue same cycle keep count=DEPTH, tail wraps to 0.
//  5 Flush during WAIT
//    -> count=0 next cycle, late resp yields no ld_valid.
//    -> a new LW then issues normally.
//  6 Load to 0x30000 with LSB_LOAD_SPEC_EN -> waits for commit.
//    Load to 0x1000 -> issues before commit.

Source files
------------

// File: rtl/lsb_pkg.sv
// lsb_pkg: op codes, access-size encoding, queue entry layout and FSM states
// shared by the load/store queue, its bus interface and the load extender.
package lsb_pkg;

    localparam int OP_W      = 3;
    localparam int LSB_XLEN  = 32;
    localparam int LSB_TAG_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsb_op_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } lsb_state_e;

    typedef struct packed {
        lsb_op_e                op;
        logic                   qj_v;
        logic [LSB_TAG_W-1:0]   qj;
        logic [LSB_XLEN-1:0]    vj;
        logic                   qk_v;
        logic [LSB_TAG_W-1:0]   qk;
        logic [LSB_XLEN-1:0]    vk;
        logic [LSB_XLEN-1:0]    imm;
        logic [LSB_TAG_W-1:0]   rob;
        logic                   committed;
        logic                   valid;
    } lsb_entry_t;

    function automatic logic op_is_store(input lsb_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input lsb_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_B;
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            default:              return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsb_queue_if.sv
// lsb_queue_if: dispatch, snoop, commit, memctrl and result signals of lsb_queue.
// slave is the queue side, master the surrounding pipeline / memory side.
interface lsb_queue_if #(
    parameter int DEPTH     = 16,
    parameter int ROB_TAG_W = 4,
    parameter int XLEN      = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       rdy;
    logic                       flush;
    logic                       disp_valid;
    logic [lsb_pkg::OP_W-1:0]   disp_op;
    logic                       disp_qj_v;
    logic [ROB_TAG_W-1:0]       disp_qj;
    logic [XLEN-1:0]            disp_vj;
    logic                       disp_qk_v;
    logic [ROB_TAG_W-1:0]       disp_qk;
    logic [XLEN-1:0]            disp_vk;
    logic [XLEN-1:0]            disp_imm;
    logic [ROB_TAG_W-1:0]       disp_rob;
    logic                       full;
    logic [CNT_W-1:0]           count;
    logic                       cdb_valid;
    logic [ROB_TAG_W-1:0]       cdb_tag;
    logic [XLEN-1:0]            cdb_data;
    logic                       rob_commit_valid;
    logic [ROB_TAG_W-1:0]       rob_commit_tag;
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic                       mem_req_we;
    logic [1:0]                 mem_req_size;
    logic [XLEN-1:0]            mem_req_addr;
    logic [XLEN-1:0]            mem_req_wdata;
    logic                       mem_resp_valid;
    logic [XLEN-1:0]            mem_resp_data;
    logic                       ld_valid;
    logic [ROB_TAG_W-1:0]       ld_tag;
    logic [XLEN-1:0]            ld_data;
    logic                       st_done_valid;
    logic [ROB_TAG_W-1:0]       st_done_tag;

    modport slave (
        input  rdy, flush, disp_valid, disp_op, disp_qj_v, disp_qj, disp_vj,
               disp_qk_v, disp_qk, disp_vk, disp_imm, disp_rob,
               cdb_valid, cdb_tag, cdb_data, rob_commit_valid, rob_commit_tag,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output full, count, mem_req_valid, mem_req_we, mem_req_size,
               mem_req_addr, mem_req_wdata, ld_valid, ld_tag, ld_data,
               st_done_valid, st_done_tag
    );

    modport master (
        output rdy, flush, disp_valid, disp_op, disp_qj_v, disp_qj, disp_vj,
               disp_qk_v, disp_qk, disp_vk, disp_imm, disp_rob,
               cdb_valid, cdb_tag, cdb_data, rob_commit_valid, rob_commit_tag,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  full, count, mem_req_valid, mem_req_we, mem_req_size,
               mem_req_addr, mem_req_wdata, ld_valid, ld_tag, ld_data,
               st_done_valid, st_done_tag
    );

endinterface

// File: rtl/lsb_load_ext.sv
// lsb_load_ext: sign/zero extension of a memory response according to the load op.
module lsb_load_ext
    import lsb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsb_op_e         op_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_LB:   data_o = {{(XLEN-8){data_i[7]}},  data_i[7:0]};
            OP_LBU:  data_o = {{(XLEN-8){1'b0}},       data_i[7:0]};
            OP_LH:   data_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
            OP_LHU:  data_o = {{(XLEN-16){1'b0}},       data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue with operand snooping and one memctrl port.
// Build option LSB_LOAD_SPEC_EN lets loads below IO_BASE issue ahead of commit.
module lsb_queue
    import lsb_pkg::*;
#(
    parameter int              DEPTH     = 16,
    parameter int              ROB_TAG_W = LSB_TAG_W,
    parameter int              XLEN      = LSB_XLEN,
    parameter logic [XLEN-1:0] IO_BASE   = 32'h30000
) (
    input logic        clk,
    input logic        rst,
    lsb_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsb_entry_t             ent_all [DEPTH];
    lsb_entry_t             head_e;
    lsb_entry_t             new_e;
    logic [PTR_W-1:0]       head_q, tail_q;
    logic [CNT_W-1:0]       count_q;
    lsb_state_e             state_q, state_d;
    logic                   issue, pop, enq, full;
    logic [XLEN-1:0]        head_addr;
    logic                   head_store, load_ok, can_issue;

    logic                   req_we_q;
    logic [1:0]             req_size_q;
    logic [XLEN-1:0]        req_addr_q, req_wdata_q;
    lsb_op_e                req_op_q;
    logic [ROB_TAG_W-1:0]   req_rob_q;
    logic                   ld_valid_q, st_done_q;
    logic [ROB_TAG_W-1:0]   ld_tag_q, st_tag_q;
    logic [XLEN-1:0]        ld_data_q, ext_data;

    function automatic logic bus_hit(input logic pend, input logic [ROB_TAG_W-1:0] tag,
                                     input logic bv, input logic [ROB_TAG_W-1:0] btag);
        return pend && bv && (tag == btag);
    endfunction

    // Incoming entry, with same-cycle broadcasts and commit folded in.
    always_comb begin
        new_e           = '0;
        new_e.valid     = 1'b1;
        new_e.op        = lsb_op_e'(bus.disp_op);
        new_e.qj_v      = bus.disp_qj_v;
        new_e.qj        = bus.disp_qj;
        new_e.vj        = bus.disp_vj;
        new_e.qk_v      = bus.disp_qk_v;
        new_e.qk        = bus.disp_qk;
        new_e.vk        = bus.disp_vk;
        new_e.imm       = bus.disp_imm;
        new_e.rob       = bus.disp_rob;
        new_e.committed = bus.rob_commit_valid && (bus.rob_commit_tag == bus.disp_rob);
        if (bus_hit(bus.disp_qj_v, bus.disp_qj, bus.cdb_valid, bus.cdb_tag)) begin
            new_e.qj_v = 1'b0;
            new_e.vj   = bus.cdb_data;
        end
        if (bus_hit(bus.disp_qj_v, bus.disp_qj, ld_valid_q, ld_tag_q)) begin
            new_e.qj_v = 1'b0;
            new_e.vj   = ld_data_q;
        end
        if (bus_hit(bus.disp_qk_v, bus.disp_qk, bus.cdb_valid, bus.cdb_tag)) begin
            new_e.qk_v = 1'b0;
            new_e.vk   = bus.cdb_data;
        end
        if (bus_hit(bus.disp_qk_v, bus.disp_qk, ld_valid_q, ld_tag_q)) begin
            new_e.qk_v = 1'b0;
            new_e.vk   = ld_data_q;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        lsb_entry_t ent_q, ent_d;

        always_comb begin
            ent_d = ent_q;
            if (ent_q.valid) begin
                if (bus_hit(ent_q.qj_v, ent_q.qj, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d.qj_v = 1'b0;
                    ent_d.vj   = bus.cdb_data;
                end
                if (bus_hit(ent_q.qj_v, ent_q.qj, ld_valid_q, ld_tag_q)) begin
                    ent_d.qj_v = 1'b0;
                    ent_d.vj   = ld_data_q;
                end
                if (bus_hit(ent_q.qk_v, ent_q.qk, bus.cdb_valid, bus.cdb_tag)) begin
                    ent_d.qk_v = 1'b0;
                    ent_d.vk   = bus.cdb_data;
                end
                if (bus_hit(ent_q.qk_v, ent_q.qk, ld_valid_q, ld_tag_q)) begin
                    ent_d.qk_v = 1'b0;
                    ent_d.vk   = ld_data_q;
                end
                if (bus.rob_commit_valid && (ent_q.rob == bus.rob_commit_tag))
                    ent_d.committed = 1'b1;
            end
            if (pop && (head_q == PTR_W'(gi)))
                ent_d.valid = 1'b0;
            // When full, the slot leaving this cycle is also the one being written.
            if (enq && (tail_q == PTR_W'(gi)))
                ent_d = new_e;
            if (bus.flush)
                ent_d = '0;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                ent_q <= '0;
            else if (bus.rdy)
                ent_q <= ent_d;
        end

        assign ent_all[gi] = ent_q;
    end

    assign head_e     = ent_all[head_q];
    assign head_addr  = head_e.vj + head_e.imm;
    assign head_store = op_is_store(head_e.op);

`ifdef LSB_LOAD_SPEC_EN
    assign load_ok = head_e.committed || (head_addr < IO_BASE);
`else
    assign load_ok = head_e.committed;
    wire unused_io_base = &{1'b0, IO_BASE};
`endif

    assign can_issue = head_e.valid && !head_e.qj_v &&
                       (head_store ? (!head_e.qk_v && head_e.committed) : load_ok);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign enq       = bus.disp_valid && !bus.flush && (!full || pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.flush && can_issue) begin
                    state_d = REQ;
                    issue   = 1'b1;
                end
            end
            REQ: begin
                // A handshake in the flush cycle still owes us a response.
                if (bus.flush)
                    state_d = bus.mem_req_ready ? DRAIN : IDLE;
                else if (bus.mem_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush)
                    state_d = bus.mem_resp_valid ? IDLE : DRAIN;
                else if (bus.mem_resp_valid) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.mem_resp_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lsb_load_ext #(.XLEN(XLEN)) u_ext (
        .op_i   (req_op_q),
        .data_i (bus.mem_resp_data),
        .data_o (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            req_we_q    <= 1'b0;
            req_size_q  <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_op_q    <= OP_LB;
            req_rob_q   <= '0;
            ld_valid_q  <= 1'b0;
            ld_tag_q    <= '0;
            ld_data_q   <= '0;
            st_done_q   <= 1'b0;
            st_tag_q    <= '0;
        end else if (bus.rdy) begin
            state_q <= state_d;
            if (bus.flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (pop)
                    head_q <= head_q + 1'b1;
                if (enq)
                    tail_q <= tail_q + 1'b1;
                if (enq && !pop)
                    count_q <= count_q + 1'b1;
                else if (pop && !enq)
                    count_q <= count_q - 1'b1;
            end
            if (issue) begin
                req_we_q    <= head_store;
                req_size_q  <= op_size(head_e.op);
                req_addr_q  <= head_addr;
                req_wdata_q <= head_store ? head_e.vk : '0;
                req_op_q    <= head_e.op;
                req_rob_q   <= head_e.rob;
            end
            ld_valid_q <= pop && !req_we_q;
            st_done_q  <= pop && req_we_q;
            if (pop && !req_we_q) begin
                ld_tag_q  <= req_rob_q;
                ld_data_q <= ext_data;
            end
            if (pop && req_we_q)
                st_tag_q <= req_rob_q;
        end
    end

    assign bus.full          = full;
    assign bus.count         = count_q;
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_req_we    = req_we_q;
    assign bus.mem_req_size  = req_size_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.ld_valid      = ld_valid_q;
    assign bus.ld_tag        = ld_tag_q;
    assign bus.ld_data       = ld_data_q;
    assign bus.st_done_valid = st_done_q;
    assign bus.st_done_tag   = st_tag_q;

endmodule
